piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per clk on a single serial line, with a frame qualifier.
- Produces the bit stream that a downstream D flip-flop or shift-register receiver samples on posedge clk.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = transmit MSB first, 1 = transmit LSB first.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on an accept edge.
- load_valid  input  1  word on din is valid.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data, registered.
- frame  output  1  high while sout carries a data or parity bit, registered.
- done  output  1  one-cycle pulse coincident with the final bit of a word, registered.

Behaviour:
- Reset (async, active-high):
  - While reset is high: sout=0, frame=0, done=0, load_ready=0, state=IDLE, shift register and bit counter cleared.
  - load_ready goes to 1 combinationally once reset deasserts.
- States:
  - IDLE: load_ready=1, frame=0, sout=0.
  - SHIFT: WIDTH cycles, bit counter runs 0..WIDTH-1.
  - PARITY: exists only with the optional feature.
- Accept:
  - Occurs on a posedge where load_valid=1 and load_ready=1. din is copied to the shift register.
  - Latency: the first bit appears on sout in the cycle after the accept edge, with frame=1.
- SHIFT:
  - Each posedge presents the next bit. Bit order is din[WIDTH-1] down to din[0] (LSB_FIRST=0), or din[0] up to din[WIDTH-1] (LSB_FIRST=1).
  - frame stays 1 for exactly WIDTH consecutive cycles.
- Final bit cycle (counter = WIDTH-1, or the PARITY cycle when enabled):
  - done=1 and load_ready=1.
  - If load_valid=1 in this cycle, the new word is accepted and its first bit follows with no gap: frame stays high continuously and the state remains SHIFT with the counter reloaded to 0.
  - Otherwise the state returns to IDLE and frame drops the next cycle.
- Busy: load_ready=0 in every non-final SHIFT cycle. load_valid is ignored and din changes have no effect.
- Counter width is $clog2(WIDTH+1), with no wrap beyond WIDTH-1. Counter and state transitions are fully defined for every WIDTH in range.
- Reset mid-frame: the frame is aborted immediately. Outputs take reset values asynchronously and no done pulse is produced. After release the block is in IDLE.
- Simultaneous reset and accept: reset wins and the word is dropped.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra PARITY cycle carries even parity, computed as the XOR of all bits of the accepted word.
  - frame spans WIDTH+1 cycles.
  - done and load_ready are asserted on the PARITY cycle, not the last data bit.
  - Back-to-back accept happens from the PARITY cycle.
- Undefined: no PARITY state, frame spans WIDTH cycles, and no parity logic is synthesized.

Test Plan:
- Basic MSB-first (WIDTH=8, LSB_FIRST=0): reset 3 cycles, then load 8'hA5 for one cycle -> next 8 cycles sout = 1,0,1,0,0,1,0,1, frame=1 for exactly 8 cycles, done=1 only on the 8th, load_ready=0 on cycles 1-7.
- LSB-first (LSB_FIRST=1): load 8'hC1 -> sout = 1,0,0,0,0,0,1,1; frame 8 cycles; done on the last bit.
- Back-to-back: load 8'hFF, hold load_valid with din=8'h00 through the final-bit cycle -> frame high 16 continuous cycles, sout eight 1s then eight 0s, done pulses on cycles 8 and 16.
- Busy rejection: during the frame of 8'hA5, drive load_valid=1 with din=8'h3C on cycles 2-5 -> serial stream unchanged (still A5), no extra frame afterwards.
- Reset mid-frame: load 8'hF0, assert reset asynchronously (between edges) after 3 bits -> sout, frame, done go to 0 immediately with no done pulse. After release load_ready=1, and a new 8'h81 load transmits correctly.
- PISO_PARITY_EN defined: load 8'h07 -> sout = 0,0,0,0,0,1,1,1 then parity 1. frame 9 cycles, done on the 9th. Load 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with frame and done qualifiers
// Optional even-parity trailer bit: define PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             frame,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;
    logic             final_bit;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Bit that leaves the word first, and the word with that bit removed
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // State, counter and sout describe the bit currently on the line, so the
    // last-bit cycle is recognisable directly from the registered state.
`ifdef PISO_PARITY_EN
    assign final_bit = (state_q == PARITY);
`else
    assign final_bit = (state_q == SHIFT) && (cnt_q == LAST);
`endif

    assign load_ready = ~reset & ((state_q == IDLE) | final_bit);
    assign accept     = load_valid & load_ready;

    assign sout  = sout_q;
    assign frame = frame_q;
    assign done  = done_q;

    // State register and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            sout_q   <= 1'b0;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            sout_q   <= sout_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: an accept always restarts a word, otherwise walk the frame
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        sout_d   = 1'b0;
        frame_d  = 1'b0;
        done_d   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (accept) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            sout_d   = lead_bit(din);
            shreg_d  = advance(din);
            frame_d  = 1'b1;
`ifdef PISO_PARITY_EN
            parity_d = ^din;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
                        sout_d  = parity_q;
                        frame_d = 1'b1;
                        done_d  = 1'b1;
`else
                        state_d = IDLE;
                        cnt_d   = '0;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        sout_d  = lead_bit(shreg_q);
                        shreg_d = advance(shreg_q);
                        frame_d = 1'b1;
`ifndef PISO_PARITY_EN
                        done_d  = ((cnt_q + 1'b1) == LAST);
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized self-checking bench for piso_serializer (MSB and LSB instances)
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int N = 80;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         load_valid;
    logic         rdy_m, sout_m, frame_m, done_m;
    logic         rdy_l, sout_l, frame_l, done_l;

    int tests;
    int fails;

    // Per-cycle stimulus and observation: obs/expv = {sm, sl, fm, fl, dm, dl, rm, rl}
    logic         sv [N];
    logic [W-1:0] sd [N];
    logic [7:0]   obs [N];
    logic [7:0]   expv [N];

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(rdy_m), .sout(sout_m), .frame(frame_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(rdy_l), .sout(sout_l), .frame(frame_l), .done(done_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // k-th bit of a frame carrying w: data bits in line order, then parity
    function automatic logic frame_bit(input logic [W-1:0] w, input int k, input bit lsb);
        if (k >= W) return ^w;
        return lsb ? w[k] : w[W-1-k];
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < N; c++) begin
            sv[c] = 1'b0;
            sd[c] = W'($urandom);
        end
    endtask

    // Frame-level reference: a word is taken when offered while no frame owns
    // the line past the previous cycle; it then occupies FL consecutive cycles.
    task automatic build_model(input int n);
        logic bm [N];
        logic bl [N];
        logic fr [N];
        logic dn [N];
        int   last_busy;
        last_busy = -1;
        for (int k = 0; k < N; k++) begin
            bm[k] = 1'b0; bl[k] = 1'b0; fr[k] = 1'b0; dn[k] = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            if (sv[c] && last_busy < c) begin
                for (int k = 0; k < FL; k++) begin
                    if (c + k < N) begin
                        bm[c+k] = frame_bit(sd[c], k, 1'b0);
                        bl[c+k] = frame_bit(sd[c], k, 1'b1);
                        fr[c+k] = 1'b1;
                        dn[c+k] = (k == FL - 1);
                    end
                end
                last_busy = c + FL - 1;
            end
        end
        for (int k = 0; k < N; k++) begin
            expv[k] = {bm[k], bl[k], fr[k], fr[k], dn[k], dn[k],
                       (!fr[k] || dn[k]), (!fr[k] || dn[k])};
        end
    endtask

    // Apply stimulus for n edges; record outputs on the falling edge after each
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            load_valid = sv[c];
            din        = sd[c];
            @(posedge clk);
            @(negedge clk);
            obs[c] = {sout_m, sout_l, frame_m, frame_l, done_m, done_l, rdy_m, rdy_l};
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_valid = 1'b0;
        din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({sout_m, sout_l, frame_m, frame_l, done_m, done_l, rdy_m, rdy_l} !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold outputs=%b required 00000000",
                     {sout_m, sout_l, frame_m, frame_l, done_m, done_l, rdy_m, rdy_l});
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({frame_m, frame_l, rdy_m, rdy_l} !== 4'b0011) begin
            fails++;
            $display("FAIL reset_release frame/ready=%b required 0011",
                     {frame_m, frame_l, rdy_m, rdy_l});
        end
    endtask

    task automatic test_single(input logic [W-1:0] w);
        int n;
        n = FL + 3;
        clear_stim();
        sv[0] = 1'b1;
        sd[0] = w;
        run_cycles(n);
        build_model(n);
        for (int k = 0; k < n; k++) begin
            tests++;
            if (obs[k] !== expv[k]) begin
                fails++;
                $display("FAIL single_%h cyc=%0d got=%b required=%b", w, k, obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 2 * FL + 3;
        clear_stim();
        for (int c = 0; c <= FL; c++) begin
            sv[c] = 1'b1;
            sd[c] = (c == 0) ? 8'hFF : 8'h00;
        end
        run_cycles(n);
        build_model(n);
        for (int k = 0; k < n; k++) begin
            tests++;
            if (obs[k] !== expv[k]) begin
                fails++;
                $display("FAIL back_to_back cyc=%0d got=%b required=%b", k, obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_busy_reject();
        int n;
        n = FL + 4;
        clear_stim();
        sv[0] = 1'b1;
        sd[0] = 8'hA5;
        for (int c = 2; c <= 5; c++) begin
            sv[c] = 1'b1;
            sd[c] = 8'h3C;
        end
        run_cycles(n);
        build_model(n);
        for (int k = 0; k < n; k++) begin
            tests++;
            if (obs[k] !== expv[k]) begin
                fails++;
                $display("FAIL busy_reject cyc=%0d got=%b required=%b", k, obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        clear_stim();
        sv[0] = 1'b1;
        sd[0] = 8'hF0;
        run_cycles(3);
        build_model(3);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs[k] !== expv[k]) begin
                fails++;
                $display("FAIL midreset_pre cyc=%0d got=%b required=%b", k, obs[k], expv[k]);
            end
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({sout_m, sout_l, frame_m, frame_l, done_m, done_l, rdy_m, rdy_l} !== 8'h00) begin
            fails++;
            $display("FAIL midreset_async outputs=%b required 00000000",
                     {sout_m, sout_l, frame_m, frame_l, done_m, done_l, rdy_m, rdy_l});
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({frame_m, frame_l, done_m, done_l} !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_held frame/done=%b required 0000",
                     {frame_m, frame_l, done_m, done_l});
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({rdy_m, rdy_l} !== 2'b11) begin
            fails++;
            $display("FAIL midreset_release ready=%b required 11", {rdy_m, rdy_l});
        end
        n = FL + 3;
        clear_stim();
        sv[0] = 1'b1;
        sd[0] = 8'h81;
        run_cycles(n);
        build_model(n);
        for (int k = 0; k < n; k++) begin
            tests++;
            if (obs[k] !== expv[k]) begin
                fails++;
                $display("FAIL midreset_after cyc=%0d got=%b required=%b", k, obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        n = 50;
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            for (int c = 0; c < n - FL - 3; c++) begin
                sv[c] = ($urandom_range(0, 3) != 0);
            end
            run_cycles(n);
            build_model(n);
            for (int k = 0; k < n; k++) begin
                tests++;
                if (obs[k] !== expv[k]) begin
                    fails++;
                    $display("FAIL random_%0d cyc=%0d got=%b required=%b", r, k, obs[k], expv[k]);
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single(8'hA5);
        test_single(8'hC1);
        test_single(8'h07);
        test_single(8'h03);
        test_back_to_back();
        test_busy_reject();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
